// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
// Shares one iterative AND/OR/SLL/SRA unit between two requesters using
// round-robin arbitration. Shifts go through one barrel stage per clock
// (16 at accept, then 8, 4, 2, 1), so only a single 32-bit stage register
// is needed. Results come back on one response channel tagged with the
// issuing requester's ID.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. reqN_ready is combinational from the valids, so requesters
// must not wait for ready before raising valid. They hold op/a/b stable
// until accepted. resp_valid stays high, with resp_id/resp_data stable,
// until resp_ready is seen high.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   req0_* / req1_*     valid, ready, op (00 AND, 01 OR, 10 SLL, 11 SRA),
//                       a, b (shifts use b[4:0])
//   resp_valid/ready    result handshake
//   resp_id, resp_data  registered result tag and value
//   dbg_state           current FSM state (0 IDLE, 1 SHIFT, 2 RESP)
module alu_op_scheduler (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [1:0]  step_q, step_d;
  logic        sra_q, sra_d;
  // amt[4] is consumed at accept time, so only the low four bits are kept.
  logic [3:0]  amt_q, amt_d;
  logic        id_q, id_d;
  // Stage register; it also holds the final result shown on resp_data.
  logic [31:0] data_q, data_d;

  logic        grant0, grant1, idle;
  logic [1:0]  sel_op;
  logic [31:0] sel_a, sel_b;

  // One of the 8/4/2/1 stages. SRA fills with the current bit 31.
  function automatic logic [31:0] shift_stage(input logic [31:0] v,
                                              input logic sra,
                                              input logic [1:0] step);
    logic f;
    f = sra & v[31];
    case (step)
      2'd0:    return sra ? {{8{f}}, v[31:8]} : {v[23:0], 8'b0};
      2'd1:    return sra ? {{4{f}}, v[31:4]} : {v[27:0], 4'b0};
      2'd2:    return sra ? {{2{f}}, v[31:2]} : {v[29:0], 2'b0};
      default: return sra ? {f, v[31:1]}     : {v[30:0], 1'b0};
    endcase
  endfunction

  // last_q==1 means requester 1 was granted last, so requester 0 wins a tie.
  assign idle   = (state_q == S_IDLE);
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);

  assign req0_ready = idle & grant0 & ~reset;
  assign req1_ready = idle & grant1 & ~reset;

  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;

  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    step_d  = step_q;
    sra_d   = sra_q;
    amt_d   = amt_q;
    id_d    = id_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (grant0 | grant1) begin
          last_d = grant1;
          id_d   = grant1;
          sra_d  = sel_op[0];
          amt_d  = sel_b[3:0];
          case (sel_op)
            2'b00: begin
              data_d  = sel_a & sel_b;
              state_d = S_RESP;
            end
            2'b01: begin
              data_d  = sel_a | sel_b;
              state_d = S_RESP;
            end
            default: begin
              // The 16-bit stage is folded into the accept cycle.
              if (sel_b[4]) begin
                data_d = sel_op[0] ? {{16{sel_a[31]}}, sel_a[31:16]}
                                   : {sel_a[15:0], 16'b0};
              end else begin
                data_d = sel_a;
              end
              step_d  = 2'd0;
              state_d = S_SHIFT;
            end
          endcase
        end
      end
      S_SHIFT: begin
        // Every stage is visited even when its bit is clear, which keeps
        // the latency fixed.
        if (amt_q[2'd3 - step_q]) begin
          data_d = shift_stage(data_q, sra_q, step_q);
        end
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      step_q  <= 2'd0;
      sra_q   <= 1'b0;
      amt_q   <= 4'd0;
      id_q    <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      step_q  <= step_d;
      sra_q   <= sra_d;
      amt_q   <= amt_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
module tb_alu_op_scheduler;

  logic        clock, reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;
  logic [1:0]  dbg_state;

  alu_op_scheduler dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time expired, expected $finish earlier");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [32:0] exp_q[$];   // {id, data}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model straight from the operation definitions.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a << b[4:0];
      default: return sa >>> b[4:0];
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op);
    return op[1] ? 5 : 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Issue one op on a single requester with resp_ready=1 and check ready,
  // latency, result, id and the return to IDLE.
  task automatic run_op(input bit id, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_d,
                        input int exp_lat, input string tag);
    int lat;
    @(negedge clock);
    resp_ready = 1'b1;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    chk({tag, " ready"}, {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    lat = 0;
    while (lat < 20) begin
      @(negedge clock);
      req0_valid = 1'b0; req1_valid = 1'b0;
      lat++;
      if (resp_valid) break;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " data"}, resp_data, exp_d);
    chk({tag, " id"}, {31'd0, resp_id}, {31'd0, id});
    @(negedge clock);
    chk({tag, " idle_after"}, {29'd0, dbg_state, resp_valid}, 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  logic        acc0, acc1, exp_turn;
  int          n_acc, lat;
  logic [31:0] held;
  logic [32:0] got;

  initial begin
    vecs[0] = '{1'b0, 2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1};
    vecs[1] = '{1'b1, 2'b11, 32'h8000_0010, 32'h0000_001F, 32'hFFFF_FFFF, 5};
    vecs[2] = '{1'b1, 2'b10, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 5};
    vecs[3] = '{1'b1, 2'b11, 32'h8000_0010, 32'h0000_0000, 32'h8000_0010, 5};
    vecs[4] = '{1'b0, 2'b01, 32'hA000_0005, 32'h0500_0050, 32'hA500_0055, 1};
    vecs[5] = '{1'b0, 2'b10, 32'h1234_5678, 32'h0000_0004, 32'h2345_6780, 5};
    vecs[6] = '{1'b1, 2'b11, 32'hF000_0000, 32'hFFFF_FFE4, 32'hFF00_0000, 5};
    vecs[7] = '{1'b0, 2'b11, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 5};

    // Reset state, with both requesters pushing.
    reset = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h1; req0_b = 32'h2;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 32'h4; req1_b = 32'h8;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("reset readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("reset state", {30'd0, dbg_state}, 32'd0);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_id", {31'd0, resp_id}, 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    @(negedge clock);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    // Table of directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_d,
             vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Contention: both valid with OR every cycle; grants alternate from 0.
    do_reset();
    exp_turn = 1'b0; n_acc = 0; acc0 = 1'b0; acc1 = 1'b0;
    req0_op = 2'b01; req1_op = 2'b01;
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    for (int cyc = 0; cyc < 60 && n_acc < 12; cyc++) begin
      @(negedge clock);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rr unexpected_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          got = exp_q.pop_front();
          chk("rr resp_id", {31'd0, resp_id}, {31'd0, got[32]});
          chk("rr resp_data", resp_data, got[31:0]);
        end
      end
      if (acc0) begin req0_a = $urandom; req0_b = $urandom; end
      if (acc1) begin req1_a = $urandom; req1_b = $urandom; end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rr one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
      acc0 = req0_ready; acc1 = req1_ready;
      if (acc0 | acc1) begin
        chk("rr grant_id", {31'd0, acc1}, {31'd0, exp_turn});
        exp_q.push_back({acc1, acc1 ? (req1_a | req1_b) : (req0_a | req0_b)});
        exp_turn = ~exp_turn;
        n_acc++;
      end
    end
    chk("rr accept_count", n_acc, 12);
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (resp_valid && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      chk("rr last_resp_data", resp_data, got[31:0]);
    end
    chk("rr queue_drained", exp_q.size(), 0);
    @(negedge clock);

    // Backpressure: SLL by 4 with resp_ready low for 10 cycles.
    @(negedge clock);
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'h1234_5678; req0_b = 32'h4;
    lat = 0;
    while (lat < 20) begin
      @(negedge clock);
      req0_valid = 1'b0;
      lat++;
      if (resp_valid) break;
    end
    chk("bp latency", lat, 5);
    held = 32'h2345_6780;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 2'b00; req1_op = 2'b01;
      #1;
      chk($sformatf("bp%0d resp_valid", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp%0d data", i), resp_data, held);
      chk($sformatf("bp%0d readys", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clock);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    #1;
    chk("bp handshake_valid", {31'd0, resp_valid}, 32'd1);
    @(negedge clock);
    chk("bp idle_after", {29'd0, dbg_state, resp_valid}, 32'd0);

    // Reset in cycle 3 of an SRA aborts it.
    do_reset();
    @(negedge clock);
    req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'h8000_0010; req0_b = 32'h8;
    #1;
    chk("rst_mid ready0", {31'd0, req0_ready}, 32'd1);
    @(negedge clock);                        // cycle 1
    req0_valid = 1'b0;
    @(negedge clock);                        // cycle 2
    @(negedge clock);                        // cycle 3
    reset = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1;
    #1;
    chk("rst_mid readys_c3", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clock);                        // cycle 4, reset still high
    chk("rst_mid state", {30'd0, dbg_state}, 32'd0);
    chk("rst_mid resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid resp_data", resp_data, 32'd0);
    chk("rst_mid resp_id", {31'd0, resp_id}, 32'd0);
    chk("rst_mid readys_c4", {30'd0, req1_ready, req0_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_mid first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rst_mid resp_valid_after", {31'd0, resp_valid}, 32'd1);
    chk("rst_mid resp_id_after", {31'd0, resp_id}, 32'd0);
    chk("rst_mid resp_data_after", resp_data, 32'h0000_00FF);
    @(negedge clock);

    // Randomized sweep: every shift amount for SLL and SRA, plus AND/OR.
    for (int amt = 0; amt < 32; amt++) begin
      for (int s = 0; s < 2; s++) begin
        logic [1:0]  op;
        logic [31:0] a, b;
        bit          id;
        op = (s == 0) ? 2'b10 : 2'b11;
        a  = $urandom;
        b  = ($urandom & 32'hFFFF_FFE0) | 32'(amt);
        id = 1'($urandom_range(0, 1));
        run_op(id, op, a, b, ref_result(op, a, b), ref_latency(op),
               $sformatf("rnd_sh%0d_%0d", amt, s));
      end
    end
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      bit          id;
      op = 2'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      id = 1'($urandom_range(0, 1));
      run_op(id, op, a, b, ref_result(op, a, b), ref_latency(op),
             $sformatf("rnd_logic%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
